mux_rr_arbiter: RTL
===================

// Module: mux_rr_arbiter
// PURPOSE
//   Round-robin arbiter and sequencer for the shared 16-bit 8:1 mux datapath.
//   Eight requesters compete for one 16-bit downstream port. The block picks one
//   requester, drives the 3-bit mux select, and holds that select until the
//   downstream consumer accepts the word through a valid/ready handshake.
//   It sits between the requesting units and the shared result bus.
// PARAMETERS
//   N_REQ  8   number of requesters; fixed at 8 to match the 8:1 mux
//   DW     16  data width per requester and at the output
//   SELW   3   select width; must equal log2(N_REQ)
// PORTS
//   clk        in   1       rising-edge clock
//   rst_n      in   1       synchronous reset, active-low
//   req        in   8       req[i]=1: requester i holds a word on its data slice
//   req_data   in   8*DW    flattened inputs; slice i = req_data[i*DW +: DW]
//   ack        out  8       one-hot pulse, one cycle, on the cycle requester i's word transfers
//   sel        out  SELW    registered mux select of the current grant
//   out_valid  out  1       output word is valid
//   out_data   out  DW      equals slice sel of req_data (combinational mux)
//   out_ready  in   1       downstream accepts the word when out_valid=1
//   busy       out  1       1 while in GRANT
// BEHAVIOUR
//   Reset (rst_n=0 at a clk edge)
//   - state=IDLE, sel=0, last=7, ack=0, out_valid=0, busy=0.
//   - Because last resets to 7, requester 0 has first priority after reset.
//   - Reset asserted mid-GRANT drops the grant with no ack. Any pending word is lost.
//   State machine: IDLE, GRANT. Transfer condition: xfer = out_valid & out_ready.
//   IDLE
//   - If |req, choose the first i with req[i]=1, scanning last+1, last+2, ... mod 8.
//   - Register sel=i and go to GRANT.
//   - out_valid rises on the next cycle, so latency from req to out_valid is 1 cycle.
//   GRANT
//   - out_valid = req[sel]. out_data = slice sel.
//   - On xfer: ack[sel]=1 for that cycle; last<=sel.
//       - If another requester j != sel has req[j]=1, re-arbitrate from the new
//         last in the same cycle. Load sel=j and stay in GRANT, so there is no bubble.
//       - Otherwise go to IDLE.
//       - The just-served requester is excluded from that same-cycle re-arbitration.
//         It is eligible again on the following cycle.
//   - If req[sel] drops without xfer: go to IDLE, no ack, last unchanged (grant withdrawn).
//   - out_ready=0 with req[sel]=1: hold sel and out_valid; out_data tracks the slice.
//   Handshake rules
//   - A requester holds req and its data stable until it sees ack.
//   - Downstream may assert out_ready at any time. Only xfer is significant.
//   Other rules
//   - ack is one-hot or zero. At most one transfer per cycle.
//   - last is updated only on xfer, which gives fairness. With all 8 requesting
//     continuously, grants go 0,1,...,7,0,... and each requester gets 1 transfer per 8.
//   - Index arithmetic is modulo 8 and wraps naturally in SELW=3 bits.
//   - sel is registered, so out_data has a single combinational mux level from req_data.
// TESTING
//   1. Reset, then req=8'h01, data0=16'hA5A5, out_ready=1:
//      - next cycle sel=0, out_valid=1, out_data=A5A5, ack=8'h01.
//      - Following cycle IDLE, out_valid=0.
//   2. req=8'hFF held, every requester re-raising after its ack, out_ready=1:
//      - acks in order 0,1,...,7,0, one per cycle with no bubble after the first grant.
//   3. Grant on 3 with out_ready=0 for 5 cycles, then 1:
//      - sel stays 3, out_valid stays 1, ack stays 0; single ack[3] on the release cycle.
//   4. last=5, req=8'h41 (requesters 0 and 6): grant 6 first, then 0; the scan wraps.
//   5. Grant on 2, then req[2] drops with out_ready=0:
//      - IDLE next cycle, no ack, last unchanged.
//      - Next arbitration resumes from the old pointer.
//   6. rst_n=0 for one cycle while in GRANT on 4:
//      - all outputs at reset values on the next cycle, no ack; then requester 0 wins first.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for the shared 8:1 result mux. It holds the registered select
// until the downstream valid/ready handshake completes, then moves on with no bubble.
module mux_rr_arbiter #(
  parameter int N_REQ = 8,
  parameter int DW    = 16,
  parameter int SELW  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]  ack,
  output logic [SELW-1:0]   sel,
  output logic              out_valid,
  output logic [DW-1:0]     out_data,
  input  logic              out_ready,
  output logic              busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state, nstate;
  logic [SELW-1:0]   last, nlast, nsel;
  logic [N_REQ-1:0]  selhot;
  logic              xfer;

  // First set bit of mask strictly after base, wrapping; offset N_REQ lands on base itself.
  function automatic logic [SELW-1:0] rrpick(input logic [N_REQ-1:0] mask,
                                             input logic [SELW-1:0] base);
    logic [SELW-1:0] idx;
    logic            found;
    rrpick = base;
    found  = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = base + SELW'(k);
      if (!found && mask[idx]) begin
        rrpick = idx;
        found  = 1'b1;
      end
    end
  endfunction

  assign selhot    = N_REQ'(1) << sel;
  assign busy      = (state == GRANT);
  assign out_valid = busy & req[sel];
  assign xfer      = out_valid & out_ready;
  assign ack       = xfer ? selhot : '0;
  assign out_data  = req_data[int'(sel)*DW +: DW];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      sel   <= '0;
      last  <= SELW'(N_REQ - 1);
    end else begin
      state <= nstate;
      sel   <= nsel;
      last  <= nlast;
    end
  end

  always_comb begin
    nstate = state;
    nsel   = sel;
    nlast  = last;
    case (state)
      IDLE: begin
        if (|req) begin
          nsel   = rrpick(req, last);
          nstate = GRANT;
        end
      end
      GRANT: begin
        if (xfer) begin
          // The served requester sits out this same-cycle re-arbitration.
          nlast = sel;
          if (|(req & ~selhot)) begin
            nsel = rrpick(req & ~selhot, sel);
          end else begin
            nstate = IDLE;
          end
        end else if (!req[sel]) begin
          nstate = IDLE;
        end
      end
      default: nstate = IDLE;
    endcase
  end

endmodule
